// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU results pass through one register; loads/stores go over the data bus.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned accesses into out_exc instead of bus traffic.

module mem_access_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_rf_we,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic              dreq_write,
  output logic [1:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_wdata,
  input  logic              dresp_valid,
  input  logic [XLEN-1:0]   dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_rf_we,
  output logic [XLEN-1:0]   out_wdata,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_exc
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int LANE_W = OFF_W + 2;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state_q, state_d;

  logic [1:0]        size_eff;
  logic [OFF_W-1:0]  size_lo;
  logic [OFF_W-1:0]  off;
  logic [LANE_W-1:0] lane_lo;
  logic [LANE_W-1:0] lane_hi;
  logic [STRB_W-1:0] strb_lanes;
  logic              is_mem, accept, take_alu, take_exc, start_bus, resp_done;

  logic [ADDR_W-1:0] dreq_addr_q, dreq_addr_d;
  logic              dreq_write_q, dreq_write_d;
  logic [1:0]        dreq_size_q, dreq_size_d;
  logic [STRB_W-1:0] dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0]   dreq_wdata_q, dreq_wdata_d;
  logic [RA_W-1:0]   slot_rd_q, slot_rd_d;
  logic              slot_we_q, slot_we_d;
  logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
  logic              slot_uns_q, slot_uns_d;
  logic [OFF_W-1:0]  slot_off_q, slot_off_d;
  logic              out_valid_q, out_valid_d;
  logic [RA_W-1:0]   out_rd_q, out_rd_d;
  logic              out_rf_we_q, out_rf_we_d;
  logic [XLEN-1:0]   out_wdata_q, out_wdata_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              out_exc_q, out_exc_d;

  logic [XLEN-1:0]   shifted, top_aligned, load_val;
  logic [6:0]        ext_sh;

  // A 32-bit datapath has no doubleword; the low offset bits below the size are dropped.
  always_comb begin
    size_eff = (XLEN == 32 && in_size == 2'd3) ? 2'd2 : in_size;
    size_lo  = OFF_W'((4'd1 << size_eff) - 4'd1);
    off      = in_alu_result[OFF_W-1:0] & ~size_lo;
    lane_lo  = LANE_W'(off);
    lane_hi  = lane_lo + LANE_W'(4'd1 << size_eff);
  end

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign strb_lanes[gi] = in_mem_write && (LANE_W'(gi) >= lane_lo) && (LANE_W'(gi) < lane_hi);
    end
  endgenerate

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(in_alu_result[OFF_W-1:0] & size_lo);
  assign take_exc   = accept && is_mem && misaligned;
`else
  assign take_exc   = 1'b0;
`endif

  assign is_mem    = in_mem_read || in_mem_write;
  assign accept    = in_valid && in_ready;
  assign take_alu  = accept && !is_mem;
  assign start_bus = accept && is_mem && !take_exc;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_bus)   state_d = WAIT;
      WAIT:    if (dresp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    dreq_valid = (state_q == WAIT);
    resp_done  = (state_q == WAIT) && dresp_valid;
  end

  always_comb begin
    dreq_addr_d   = dreq_addr_q;
    dreq_write_d  = dreq_write_q;
    dreq_size_d   = dreq_size_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_wdata_d  = dreq_wdata_q;
    slot_rd_d     = slot_rd_q;
    slot_we_d     = slot_we_q;
    slot_pc_d     = slot_pc_q;
    slot_uns_d    = slot_uns_q;
    slot_off_d    = slot_off_q;
    if (start_bus) begin
      dreq_addr_d   = ADDR_W'(in_alu_result);
      dreq_write_d  = in_mem_write;
      dreq_size_d   = size_eff;
      dreq_strobe_d = strb_lanes;
      dreq_wdata_d  = in_wdata << {off, 3'b000};
      slot_rd_d     = in_rd;
      slot_we_d     = in_rf_we;
      slot_pc_d     = in_pc;
      slot_uns_d    = in_unsigned;
      slot_off_d    = off;
    end

    // Park the loaded field at the top, then shift back down to sign- or zero-extend.
    shifted     = dresp_data >> {slot_off_q, 3'b000};
    ext_sh      = 7'(XLEN) - (7'd8 << dreq_size_q);
    top_aligned = shifted << ext_sh;
    load_val    = slot_uns_q ? (top_aligned >> ext_sh) : XLEN'($signed(top_aligned) >>> ext_sh);

    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_rf_we_d = out_rf_we_q;
    out_wdata_d = out_wdata_q;
    out_pc_d    = out_pc_q;
    out_exc_d   = out_exc_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_rd_d    = '0;
      out_rf_we_d = 1'b0;
      out_wdata_d = '0;
      out_pc_d    = '0;
      out_exc_d   = 1'b0;
    end
    if (take_alu) begin
      out_valid_d = 1'b1;
      out_rd_d    = in_rd;
      out_rf_we_d = in_rf_we;
      out_wdata_d = in_alu_result;
      out_pc_d    = in_pc;
      out_exc_d   = 1'b0;
    end else if (take_exc) begin
      out_valid_d = 1'b1;
      out_rd_d    = in_rd;
      out_rf_we_d = 1'b0;
      out_wdata_d = in_alu_result;
      out_pc_d    = in_pc;
      out_exc_d   = 1'b1;
    end else if (resp_done) begin
      out_valid_d = 1'b1;
      out_rd_d    = slot_rd_q;
      out_rf_we_d = dreq_write_q ? 1'b0 : slot_we_q;
      out_wdata_d = dreq_write_q ? '0 : load_val;
      out_pc_d    = slot_pc_q;
      out_exc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dreq_addr_q   <= '0;
      dreq_write_q  <= 1'b0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_wdata_q  <= '0;
      slot_rd_q     <= '0;
      slot_we_q     <= 1'b0;
      slot_pc_q     <= '0;
      slot_uns_q    <= 1'b0;
      slot_off_q    <= '0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_rf_we_q   <= 1'b0;
      out_wdata_q   <= '0;
      out_pc_q      <= '0;
      out_exc_q     <= 1'b0;
    end else begin
      dreq_addr_q   <= dreq_addr_d;
      dreq_write_q  <= dreq_write_d;
      dreq_size_q   <= dreq_size_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_wdata_q  <= dreq_wdata_d;
      slot_rd_q     <= slot_rd_d;
      slot_we_q     <= slot_we_d;
      slot_pc_q     <= slot_pc_d;
      slot_uns_q    <= slot_uns_d;
      slot_off_q    <= slot_off_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_rf_we_q   <= out_rf_we_d;
      out_wdata_q   <= out_wdata_d;
      out_pc_q      <= out_pc_d;
      out_exc_q     <= out_exc_d;
    end
  end

  assign dreq_addr   = dreq_addr_q;
  assign dreq_write  = dreq_write_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_wdata  = dreq_wdata_q;
  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_rf_we   = out_rf_we_q;
  assign out_wdata   = out_wdata_q;
  assign out_pc      = out_pc_q;
  assign out_exc     = out_exc_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage with a byte-level reference model, a bus responder
// and directed cases for sign extension, lane steering, bus stalls, backpressure and reset.

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic [63:0] in_alu_result = '0;
  logic [63:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rf_we = 1'b0;
  logic [63:0] in_pc = '0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_wdata;
  logic        dresp_valid = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_rd;
  logic        out_rf_we;
  logic [63:0] out_wdata;
  logic [63:0] out_pc;
  logic        out_exc;

  mem_access_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_alu_result(in_alu_result), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_rf_we(in_rf_we), .in_pc(in_pc),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rf_we(out_rf_we), .out_wdata(out_wdata),
    .out_pc(out_pc), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] alu;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] pc;
    logic [63:0] rdata;
    int          delay;
  } op_t;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          delay;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic        exc;
  } out_t;

  req_t req_q[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  bit   rand_ready = 1'b0;
  bit   bus_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected bus request and writeback, built byte by byte from the access rules.
  function automatic void model_push(input op_t op);
    int   bytes = 1 << op.size;
    int   offr  = int'(op.alu[2:0]);
    int   off;
    out_t o;
    req_t r;
    logic [63:0] v;
    o.rd = op.rd; o.pc = op.pc; o.exc = 1'b0; o.we = op.we; o.wdata = op.alu;
    if (op.rd_op || op.wr_op) begin
`ifdef MEM_MISALIGN_TRAP_EN
      if (offr % bytes != 0) begin
        o.we = 1'b0; o.exc = 1'b1;
        exp_q.push_back(o);
        return;
      end
`endif
      off = offr - (offr % bytes);
      r.addr = op.alu; r.write = op.wr_op; r.size = op.size;
      r.strobe = '0; r.wdata = '0; r.rdata = op.rdata; r.delay = op.delay;
      for (int b = 0; b < 8; b++) begin
        if (op.wr_op && b >= off && b < off + bytes) r.strobe[b] = 1'b1;
        if (b >= off) r.wdata[8*b +: 8] = op.wdata[8*(b-off) +: 8];
      end
      req_q.push_back(r);
      if (op.wr_op) begin
        o.we = 1'b0; o.wdata = '0;
      end else begin
        v = '0;
        for (int i = 0; i < bytes; i++) v[8*i +: 8] = op.rdata[8*(off+i) +: 8];
        if (!op.uns && bytes < 8 && v[8*bytes-1])
          for (int i = bytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        o.wdata = v;
      end
    end
    exp_q.push_back(o);
  endfunction

  task automatic set_inputs(input op_t op);
    in_valid = 1'b1; in_mem_read = op.rd_op; in_mem_write = op.wr_op;
    in_size = op.size; in_unsigned = op.uns; in_alu_result = op.alu;
    in_wdata = op.wdata; in_rd = op.rd; in_rf_we = op.we; in_pc = op.pc;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the op.
  task automatic send(input op_t op);
    bit acc = 1'b0;
    set_inputs(op);
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(op);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    txn++;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: txn %0d never accepted", txn);
    end
    $display("txn %0d: rd=%0b wr=%0b size=%0d addr=0x%0h rd_reg=%0d", txn, op.rd_op, op.wr_op, op.size, op.alu, op.rd);
  endtask

  task automatic wait_out();
    bit seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL out_timeout: out_valid never rose, got 0 expected 1");
    end
  endtask

  function automatic op_t mk(input logic r, input logic w, input logic [1:0] s, input logic u,
                             input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rdat, input int d);
    op_t op;
    op.rd_op = r; op.wr_op = w; op.size = s; op.uns = u; op.alu = a; op.wdata = wd;
    op.rd = 5'd7; op.we = 1'b1; op.pc = 64'h8000_0000 + a; op.rdata = rdat; op.delay = d;
    return op;
  endfunction

  // Output compare: holds while stalled, pops the model on each handshake.
  initial begin
    out_t e;
    out_t held;
    bit prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (out_valid && prev_hold)
          check("out_stable", {out_rd, out_rf_we, out_wdata, out_pc, out_exc},
                {held.rd, held.we, held.wdata, held.pc, held.exc});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out: out_wdata=0x%0h with no pending op", out_wdata);
          end else begin
            e = exp_q.pop_front();
            check("out_rd", 64'(out_rd), 64'(e.rd));
            check("out_rf_we", 64'(out_rf_we), 64'(e.we));
            check("out_wdata", out_wdata, e.wdata);
            check("out_pc", out_pc, e.pc);
            check("out_exc", 64'(out_exc), 64'(e.exc));
          end
        end
        prev_hold = out_valid && !out_ready;
        held.rd = out_rd; held.we = out_rf_we; held.wdata = out_wdata;
        held.pc = out_pc; held.exc = out_exc;
      end
    end
  end

  // Bus responder: acknowledges after r.delay request cycles; sprinkles stale acks while idle.
  initial begin
    req_t r;
    bit   abort;
    forever begin
      @(negedge clk);
      if (dreq_valid && !reset) begin
        abort = bus_abort;
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr=0x%0h with no pending mem op", dreq_addr);
        end else begin
          r = req_q.pop_front();
          if (!abort) begin
            check("req_addr", dreq_addr, r.addr);
            check("req_write", 64'(dreq_write), 64'(r.write));
            check("req_size", 64'(dreq_size), 64'(r.size));
            check("req_strobe", 64'(dreq_strobe), 64'(r.strobe));
            if (r.write) check("req_wdata", dreq_wdata, r.wdata);
          end
          for (int c = 1; c <= r.delay; c++) begin
            if (c > 1) @(negedge clk);
            if (!abort) begin
              check("req_hold", 64'(dreq_valid), 64'd1);
              check("req_addr_stable", dreq_addr, r.addr);
              check("in_ready_wait", 64'(in_ready), 64'd0);
            end
            if (c == r.delay) begin
              dresp_valid = 1'b1;
              dresp_data  = r.rdata;
            end
          end
          @(posedge clk); #1;
          dresp_valid = 1'b0;
          dresp_data  = {$urandom, $urandom};
          if (!abort) begin
            @(negedge clk);
            check("req_drop", 64'(dreq_valid), 64'd0);
            check("out_after_ack", 64'(out_valid), 64'd1);
          end
        end
      end else if (!reset && !bus_abort && $urandom_range(7) == 0) begin
        dresp_valid = 1'b1;
        dresp_data  = {$urandom, $urandom};
        @(posedge clk); #1;
        dresp_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(9) < 7);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t a, b;
    int  n;
    bit  stale;
    int  k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_wdata", out_wdata, 64'd0);
    check("rst_strobe", 64'(dreq_strobe), 64'd0);
    check("rst_out_exc", 64'(out_exc), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU pass-through with latency 1
    a = mk(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'h0, 64'h0, 1);
    a.rd = 5'd5;
    send(a);
    @(negedge clk);
    check("alu_valid", 64'(out_valid), 64'd1);
    check("alu_wdata", out_wdata, 64'h1234);
    check("alu_rd", 64'(out_rd), 64'd5);
    @(posedge clk); #1;

    // LB signed / unsigned from lane 3
    send(mk(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1));
    @(negedge clk);
    check("lb_req_valid", 64'(dreq_valid), 64'd1);
    check("lb_strobe", 64'(dreq_strobe), 64'd0);
    wait_out();
    check("lb_signed", out_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    @(posedge clk); #1;
    send(mk(1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2));
    wait_out();
    check("lb_unsigned", out_wdata, 64'h80);
    @(posedge clk); #1;

    // SH into lanes 6..7
    send(mk(1'b0, 1'b1, 2'd1, 1'b0, 64'h1006, 64'hBEEF, 64'h0, 2));
    @(negedge clk);
    check("sh_strobe", 64'(dreq_strobe), 64'hC0);
    check("sh_wdata", dreq_wdata, 64'hBEEF_0000_0000_0000);
    wait_out();
    check("sh_rf_we", 64'(out_rf_we), 64'd0);
    @(posedge clk); #1;

    // LD with a 3-cycle bus wait
    send(mk(1'b1, 1'b0, 2'd3, 1'b0, 64'h1008, 64'h0, 64'h0123_4567_89AB_CDEF, 3));
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (dreq_valid) n++;
      else break;
    end
    check("ld_req_cycles", 64'(n), 64'd3);
    check("ld_out_valid", 64'(out_valid), 64'd1);
    check("ld_data", out_wdata, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;

    // WB backpressure holds the slot and blocks the next op
    out_ready = 1'b0;
    a = mk(1'b0, 1'b0, 2'd0, 1'b0, 64'hAAAA_5555, 64'h0, 64'h0, 1);
    b = mk(1'b0, 1'b0, 2'd0, 1'b0, 64'h7777, 64'h0, 64'h0, 1);
    send(a);
    set_inputs(b);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_wdata", out_wdata, 64'hAAAA_5555);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(b);
    wait_out();
    check("bp_second", out_wdata, 64'h7777);
    @(posedge clk); #1;

    // Reset in the middle of a bus wait; the late ack must be ignored
    bus_abort = 1'b1;
    send(mk(1'b1, 1'b0, 2'd2, 1'b0, 64'h1010, 64'h0, 64'hFFFF_FFFF, 6));
    @(negedge clk);
    check("abort_req_valid", 64'(dreq_valid), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_req_drop", 64'(dreq_valid), 64'd0);
    exp_q.delete();
    stale = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("abort_no_out", 64'(stale), 64'd0);
    bus_abort = 1'b0;
    req_q.delete();
    @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
    send(mk(1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0, 1));
    @(negedge clk);
    check("trap_no_req", 64'(dreq_valid), 64'd0);
    check("trap_exc", 64'(out_exc), 64'd1);
    check("trap_wdata", out_wdata, 64'h1002);
    @(posedge clk); #1;
`endif

    // Randomised mix
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(2);
      a.rd_op = (k == 1);
      a.wr_op = (k == 2);
      a.size  = 2'($urandom_range(3));
      a.uns   = 1'($urandom_range(1));
      a.alu   = (k == 0) ? {$urandom, $urandom} : 64'h1000 + 64'($urandom_range(63));
      a.wdata = {$urandom, $urandom};
      a.rd    = 5'($urandom_range(31));
      a.we    = 1'($urandom_range(1));
      a.pc    = {$urandom, $urandom};
      a.rdata = {$urandom, $urandom};
      a.delay = $urandom_range(1, 4);
      send(a);
    end

    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("drain_out_q", 64'(exp_q.size()), 64'd0);
    check("drain_req_q", 64'(req_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
